// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key map,
// column reset pattern and small index helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } kp_state_e;

    localparam logic [3:0] COL_RESET = 4'b1110;

    // Nibble at index {row, col}: rows are 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col, 2'b00} +: 4];
    endfunction

    function automatic logic [1:0] col_index(input logic [3:0] col_n);
        case (col_n)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] first_low_row(input logic [3:0] rows_n);
        if (!rows_n[0])      return 2'd0;
        else if (!rows_n[1]) return 2'd1;
        else if (!rows_n[2]) return 2'd2;
        else                 return 2'd3;
    endfunction

    function automatic logic [3:0] col_rotate(input logic [3:0] col_n);
        return {col_n[2:0], col_n[3]};
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running slot divider: tick is high on the last cycle of every
// SCAN_DIV-cycle slot.
module keypad_tick_gen #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_cnt <= '0;
        else if (div_cnt == DIV_LAST)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    assign tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 keypad scanner/debouncer/encoder. Optional auto-repeat of key_valid
// while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int REPEAT_DLY   = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("keypad_scan_encoder: parameter out of range");
    end

    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic            tick;
    logic [3:0]      row_meta, row_sync;
    kp_state_e       state_q, state_d;
    logic [1:0]      row_idx_q, row_idx_d, col_idx_q, col_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]      col_d, key_code_d;
    logic            key_valid_d, key_held_d;
    logic            accept, release_done, row_low;

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int RPT_W = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DLY_V  = RPT_W'(REPEAT_DLY);
    localparam logic [RPT_W-1:0] RPT_RATE_V = RPT_W'(REPEAT_RATE);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d, rpt_inc;
    logic             rpt_phase_q, rpt_phase_d;
`endif

    keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign row_low = !row_sync[row_idx_q];

    always_comb begin
        state_d      = state_q;
        col_d        = col_n;
        row_idx_d    = row_idx_q;
        col_idx_d    = col_idx_q;
        cnt_d        = cnt_q;
        cnt_inc      = cnt_q + 1'b1;
        key_code_d   = key_code;
        key_valid_d  = 1'b0;
        key_held_d   = key_held;
        accept       = 1'b0;
        release_done = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        // Repeat counter only lives in PRESSED, so entering PRESSED starts it at zero.
        rpt_cnt_d   = (state_q == ST_PRESSED) ? rpt_cnt_q : '0;
        rpt_phase_d = (state_q == ST_PRESSED) ? rpt_phase_q : 1'b0;
        rpt_inc     = rpt_cnt_q + 1'b1;
`endif
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (&row_sync) begin
                        col_d = col_rotate(col_n);
                    end else begin
                        row_idx_d = first_low_row(row_sync);
                        col_idx_d = col_index(col_n);
                        if (DEBOUNCE_CNT == 1) begin
                            accept = 1'b1;
                        end else begin
                            state_d = ST_DEBOUNCE;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_low) begin
                        if (cnt_inc == CNT_DONE) accept = 1'b1;
                        else                     cnt_d  = cnt_inc;
                    end else begin
                        state_d = ST_SCAN;
                        cnt_d   = '0;
                        col_d   = col_rotate(col_n);
                    end
                end
                ST_PRESSED: begin
                    if (!row_low) begin
                        if (CNT_DONE == CNT_ONE) begin
                            release_done = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                            cnt_d   = CNT_ONE;
                        end
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rpt_inc == (rpt_phase_q ? RPT_RATE_V : RPT_DLY_V)) begin
                        key_valid_d = 1'b1;
                        rpt_cnt_d   = '0;
                        rpt_phase_d = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_inc;
                    end
`endif
                end
                ST_RELEASE: begin
                    if (!row_low) begin
                        if (cnt_inc == CNT_DONE) release_done = 1'b1;
                        else                     cnt_d        = cnt_inc;
                    end else begin
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end
                end
                default: state_d = ST_SCAN;
            endcase

            if (accept) begin
                key_code_d  = key_lookup(row_idx_d, col_idx_d);
                key_valid_d = 1'b1;
                key_held_d  = 1'b1;
                state_d     = ST_PRESSED;
                cnt_d       = '0;
            end
            if (release_done) begin
                key_held_d = 1'b0;
                col_d      = col_rotate(col_n);
                state_d    = ST_SCAN;
                cnt_d      = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta  <= 4'hF;
            row_sync  <= 4'hF;
            state_q   <= ST_SCAN;
            col_n     <= COL_RESET;
            row_idx_q <= '0;
            col_idx_q <= '0;
            cnt_q     <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            row_meta  <= row_n;
            row_sync  <= row_meta;
            state_q   <= state_d;
            col_n     <= col_d;
            row_idx_q <= row_idx_d;
            col_idx_q <= col_idx_d;
            cnt_q     <= cnt_d;
            key_code  <= key_code_d;
            key_valid <= key_valid_d;
            key_held  <= key_held_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q   <= '0;
            rpt_phase_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_phase_q <= rpt_phase_d;
        end
    end
`endif

endmodule
